nibble_serial_subtractor: RTL and testbench
===========================================

Name: nibble_serial_subtractor

Overview:
Multi-cycle unsigned/two's-complement subtractor computing diff = a - b - bin over WIDTH bits. It processes one 4-bit nibble per cycle using a borrow-lookahead slice, the subtract-side counterpart of the 4-bit carry-lookahead adder. The borrow is registered between nibbles. It sits in the datapath behind a valid/ready handshake on both input and output, so arithmetic units can share narrow lookahead logic across wide operands.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and >= 8.
NIB, WIDTH/4, derived number of nibble steps; not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a, b, bin valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow-in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
bout  output  1  final borrow-out; 1 iff a < b + bin (unsigned)
ovf  output  1  signed overflow
zero  output  1  diff == 0

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on rising clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, zero=0, nibble index=0, borrow register=0.
- FSM states are IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at edge k: capture a, b, and bin (into the borrow register), set idx=0, go to CALC.
- CALC: in_ready=0, out_valid=0. Each cycle operates on nibble idx of the captured operands.
  - Per bit: g_i=~a_i&b_i, p_i=~(a_i^b_i).
  - Borrows are full lookahead within the nibble, with no ripple: br1=g0|p0&br0, br2=g1|p1&g0|p1&p0&br0, and so on.
  - d_i=a_i^b_i^br_i.
  - At the clock edge, write d into diff[4*idx+3:4*idx], load the borrow register with the nibble borrow-out, and increment idx.
- After NIB steps (edge k+NIB): go to DONE.
  - bout = final borrow.
  - ovf = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), using captured a and b.
  - zero = (diff==0).
  - out_valid=1.
  - Latency from accept edge to out_valid high is exactly NIB cycles.
- Intermediate diff nibbles may update during CALC; consumers use diff only while out_valid=1.
- DONE: out_valid=1, in_ready=0. diff/bout/ovf/zero hold stable while out_ready=0 (indefinite backpressure). On out_valid&out_ready: out_valid=0, go to IDLE.
  - There is no same-cycle re-accept. A new operand is taken no earlier than the cycle after the output handshake, so throughput is 1 op per NIB+2 cycles minimum.
- Inputs a/b/bin are ignored outside the IDLE accept cycle. Changing them during CALC must not affect the result.
- in_valid while not in IDLE is ignored; it is not queued.
- rst asserted in any state, including mid-CALC or DONE with out_valid=1, aborts the operation. All outputs return to reset values at that edge, and no result is emitted.
- rst and in_valid in the same cycle: reset wins; nothing is captured.
- Wrap-around: diff is modulo 2^WIDTH. Underflow is reported only via bout, and signed overflow only via ovf.

Test Plan:
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> after 4 cycles diff=0x1000, bout=0, ovf=0, zero=0.
- a=0x1000, b=0x0001, bin=0 (borrow chains across 3 nibbles) -> diff=0x0FFF, bout=0. Then a=0x0000, b=0x0001 -> diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1, bout=0. Then a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, zero=0. Then a=b=0xABCD, bin=0 -> diff=0, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Required: outputs stable, in_ready=0, and a toggling in_valid is ignored. Release out_ready, then accept a new op the next cycle and check correct result after 4 cycles.
- Reset mid-CALC: assert rst at step 2 of 0x1234-0x0234. Next cycle: in_ready=1, out_valid=0, diff=0. A subsequent op computes correctly.
- Randomised back-to-back: 1000 ops with random in_valid/out_ready; compare against golden a-b-bin, bout, ovf; check exact NIB-cycle latency.

Source files
------------

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial borrow-lookahead subtractor
//
// Computes diff = a - b - bin over WIDTH bits, one 4-bit nibble per clock
// using a borrow-lookahead slice, with the borrow registered between nibbles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (a, b, bin)
//   a, b, bin           minuend, subtrahend, borrow-in
//   out_valid/out_ready result handshake
//   diff                a - b - bin modulo 2^WIDTH
//   bout                final borrow-out (unsigned underflow)
//   ovf                 signed overflow
//   zero                diff == 0
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  diff_q, diff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              br_q, br_d;
    logic              bout_q, bout_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;

    // Current nibble slice and its lookahead terms.
    logic [3:0] an, bn, g, p, dn;
    logic       br0, br1, br2, br3, br4;

    always_comb begin
        an = '0;
        bn = '0;
        for (int n = 0; n < NIB; n++) begin
            if (idx_q == IDXW'(n)) begin
                an = a_q[4*n +: 4];
                bn = b_q[4*n +: 4];
            end
        end

        // A bit generates a borrow when a_i=0,b_i=1 and propagates an
        // incoming borrow when a_i==b_i.
        g = ~an & bn;
        p = ~(an ^ bn);

        // Every borrow is a flat sum of products of g/p and the registered
        // borrow, so no borrow depends on another within the nibble.
        br0 = br_q;
        br1 = g[0] | (p[0] & br0);
        br2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br0);
        br3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & br0);
        br4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & br0);

        dn = an ^ bn ^ {br3, br2, br1, br0};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        idx_d   = idx_q;
        br_d    = br_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    br_d    = bin;
                    idx_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int n = 0; n < NIB; n++) begin
                    if (idx_q == IDXW'(n)) begin
                        diff_d[4*n +: 4] = dn;
                    end
                end
                br_d  = br4;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NIB - 1)) begin
                    // Flags are computed from the fully assembled result.
                    idx_d   = '0;
                    bout_d  = br4;
                    ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                            & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            idx_q   <= '0;
            br_q    <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            idx_q   <= idx_d;
            br_q    <= br_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - scoreboard bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    logic             rand_mode = 1'b0;
    logic             or_dir    = 1'b1;
    logic             or_rand   = 1'b1;

    assign out_ready = rand_mode ? or_rand : or_dir;

    nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
        logic             z;
        int               acc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic ov_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: checks latency on out_valid rising, output contents every
    // cycle out_valid is high (covers stability under backpressure), and
    // pops on the handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    if (!ov_prev) chk("latency", cyc - exp_q[0].acc, NIB);
                    chk("diff", diff, exp_q[0].d);
                    chk("bout", bout, exp_q[0].bo);
                    chk("ovf", ovf, exp_q[0].ov);
                    chk("zero", zero, exp_q[0].z);
                    chk("in_ready_busy", in_ready, 1'b0);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1 or_rand = ($urandom_range(0, 3) != 0);
        end
    end

    // Starts and ends at posedge+#1.  Returns with the operand accepted.
    task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                        input logic [15:0] ed, input logic eb, input logic eo,
                        input logic ez, input bit push);
        int   waited = 0;
        exp_t e;
        in_valid = 1'b1;
        a = ta;
        b = tb;
        bin = tbin;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else if (push) begin
            e.d = ed; e.bo = eb; e.ov = eo; e.z = ez; e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        bin = 1'($urandom);
    endtask

    task automatic send_model(input logic [15:0] ta, input logic [15:0] tb, input logic tbin);
        logic [16:0] full;
        logic [15:0] d;
        full = {1'b0, ta} - {1'b0, tb} - 17'(tbin);
        d = full[15:0];
        send(ta, tb, tbin, d, full[16], (ta[15] ^ tb[15]) & (ta[15] ^ d[15]), d == 0, 1'b1);
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(posedge clk);
            w++;
        end
        #1;
        if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_diff", diff, 16'h0);
        chk("rst_flags", {bout, ovf, zero}, 3'b000);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed vectors, hand-computed results.
        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1);
        send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
        send(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send(16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
        send(16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Backpressure: hold the result for 10 cycles while in_valid toggles.
        or_dir = 1'b0;
        send(16'h7000, 16'h9000, 1'b0, 16'hE000, 1'b1, 1'b1, 1'b0, 1'b1);
        begin
            int w = 0;
            while (!out_valid && w < 50) begin
                @(posedge clk); #1; w++;
            end
            chk("bp_out_valid", out_valid, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom);
            a = WIDTH'($urandom);
            b = WIDTH'($urandom);
            @(negedge clk);
            chk("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        or_dir = 1'b1;
        send(16'h0001, 16'hFFFF, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        drain();

        // Reset during CALC step 2; result must never appear.
        send(16'h1234, 16'h0234, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_diff", diff, 16'h0);

        // Reset and in_valid together: nothing captured.
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h1111;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("rst_vs_valid_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        send(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        // Random back-to-back with random gaps and random out_ready.
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_model(16'($urandom), 16'($urandom), 1'($urandom));
        end
        drain();
        rand_mode = 1'b0;

        repeat (3) @(posedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
